// File: rtl/xfilt_pkg.sv
// ---------------------------------------------------------------
// xfilt_pkg : shared widths and sequencer state encoding for xfilter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package xfilt_pkg;

  localparam int XFILT_XB = 10;
  localparam int XFILT_YB = 10;
  localparam int XFILT_PB = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ---------------------------------------------------------------
// raster_counter : column/row position with end-of-row/frame flags
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module raster_counter #(
  parameter int XB = 10,
  parameter int YB = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [XB-1:0] width,
  input  logic [YB-1:0] height,
  input  logic          col_inc,
  input  logic          row_adv,
  output logic [XB-1:0] col,
  output logic [YB-1:0] row,
  output logic          end_of_row,
  output logic          end_of_frame
);

  logic [XB-1:0] r_width;
  logic [YB-1:0] r_height;
  logic [XB-1:0] r_col;
  logic [YB-1:0] r_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_width  <= '0;
      r_height <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else if (load) begin
      r_width  <= width;
      r_height <= height;
      r_col    <= '0;
      r_row    <= '0;
    end else if (row_adv) begin
      r_col <= '0;
      r_row <= r_row + YB'(1);
    end else if (col_inc) begin
      r_col <= r_col + XB'(1);
    end
  end

  // Flags compare before the increment, so col never needs to exceed W.
  assign end_of_row   = (r_col == r_width - XB'(1));
  assign end_of_frame = (r_row == r_height - YB'(1));
  assign col          = r_col;
  assign row          = r_row;

endmodule

`default_nettype wire

// File: rtl/xfilter_feeder.sv
// ---------------------------------------------------------------
// xfilter_feeder : raster sequencer driving the 1-2-1 filter input
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module xfilter_feeder
  import xfilt_pkg::*;
#(
  parameter int XB = XFILT_XB,
  parameter int YB = XFILT_YB,
  parameter int PB = XFILT_PB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [XB-1:0] i_width,
  input  logic [YB-1:0] i_height,
  input  logic          s_valid,
  input  logic [PB+1:0] s_pixel,
  output logic          s_ready,
  output logic          o_valid_new_pixel,
  output logic [PB+1:0] o_new_pixel,
  output logic          o_valid_lpos,
  output logic          o_valid_cpos,
  output logic          o_valid_rpos,
  output logic          o_rowM,
  output logic          o_busy,
  output logic          o_done
);

  state_t        r_state;
  logic          r_push;
  logic [PB+1:0] r_pixel;
  logic          r_lpos;
  logic          r_cpos;
  logic          r_rpos;
  logic          r_rowM;
  logic          r_done;

  logic [XB-1:0] w_col;
  logic [YB-1:0] w_row;
  logic          w_end_row;
  logic          w_last_row;
  logic          w_load;
  logic          w_hs;
  logic          w_row_adv;
  logic          w_first;

  assign s_ready   = (r_state == S_PRIME) || (r_state == S_RUN);
  assign o_busy    = s_ready || (r_state == S_FLUSH);
  assign w_hs      = s_valid && s_ready;
  assign w_load    = (r_state == S_IDLE) && i_start;
  assign w_row_adv = (r_state == S_FLUSH) && !w_last_row;
  // The pixel being accepted at col==1 completes the window for column 0.
  assign w_first   = (w_col == XB'(1));

  raster_counter #(
    .XB(XB),
    .YB(YB)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .load        (w_load),
    .width       (i_width),
    .height      (i_height),
    .col_inc     (w_hs),
    .row_adv     (w_row_adv),
    .col         (w_col),
    .row         (w_row),
    .end_of_row  (w_end_row),
    .end_of_frame(w_last_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_push  <= 1'b0;
      r_pixel <= '0;
      r_lpos  <= 1'b0;
      r_cpos  <= 1'b0;
      r_rpos  <= 1'b0;
      r_rowM  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_lpos <= 1'b0;
      r_cpos <= 1'b0;
      r_rpos <= 1'b0;
      r_rowM <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if ((i_width < XB'(2)) || (i_height == '0)) r_state <= S_DONE;
            else                                       r_state <= S_PRIME;
          end
        end
        S_PRIME: begin
          if (w_hs) begin
            r_push  <= 1'b1;
            r_pixel <= s_pixel;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_push  <= 1'b1;
            r_pixel <= s_pixel;
            r_lpos  <= w_first;
            r_cpos  <= !w_first;
            r_rowM  <= w_last_row;
            if (w_end_row) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_rpos  <= 1'b1;
          r_rowM  <= w_last_row;
          r_state <= w_last_row ? S_DONE : S_PRIME;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_valid_new_pixel = r_push;
  assign o_new_pixel       = r_pixel;
  assign o_valid_lpos      = r_lpos;
  assign o_valid_cpos      = r_cpos;
  assign o_valid_rpos      = r_rpos;
  assign o_rowM            = r_rowM;
  assign o_done            = r_done;

endmodule

`default_nettype wire

// File: tb/tb_xfilter_feeder.sv
// ---------------------------------------------------------------
// tb_xfilter_feeder : directed self-checking bench for xfilter_feeder
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_xfilter_feeder;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [XB-1:0] i_width = '0;
  logic [YB-1:0] i_height = '0;
  logic          s_valid = 1'b0;
  logic [PB+1:0] s_pixel = '0;
  logic          s_ready;
  logic          o_valid_new_pixel;
  logic [PB+1:0] o_new_pixel;
  logic          o_valid_lpos, o_valid_cpos, o_valid_rpos;
  logic          o_rowM, o_busy, o_done;

  xfilter_feeder #(.XB(XB), .YB(YB), .PB(PB)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_width          (i_width),
    .i_height         (i_height),
    .s_valid          (s_valid),
    .s_pixel          (s_pixel),
    .s_ready          (s_ready),
    .o_valid_new_pixel(o_valid_new_pixel),
    .o_new_pixel      (o_new_pixel),
    .o_valid_lpos     (o_valid_lpos),
    .o_valid_cpos     (o_valid_cpos),
    .o_valid_rpos     (o_valid_rpos),
    .o_rowM           (o_rowM),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Per-frame trace: code = {push, lpos, cpos, rpos, rowM, done}
  logic [5:0]    tr   [0:63];
  logic [PB+1:0] tp   [0:63];
  logic          tbsy [0:63];
  logic          trdy [0:63];
  int tidx, n_acc, stall_at, stall_left;
  int n_push, n_l, n_c, n_r, n_rowm, n_done, n_busy, n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic hs;
    @(negedge clk);
    if (tidx < 64) begin
      tr[tidx]   = {o_valid_new_pixel, o_valid_lpos, o_valid_cpos, o_valid_rpos, o_rowM, o_done};
      tp[tidx]   = o_new_pixel;
      tbsy[tidx] = o_busy;
      trdy[tidx] = s_ready;
    end
    tidx++;
    n_push += int'(o_valid_new_pixel);
    n_l    += int'(o_valid_lpos);
    n_c    += int'(o_valid_cpos);
    n_r    += int'(o_valid_rpos);
    n_rowm += int'(o_rowM);
    n_done += int'(o_done);
    n_busy += int'(o_busy);
    if ((int'(o_valid_lpos) + int'(o_valid_cpos) + int'(o_valid_rpos) > 1) ||
        (o_valid_rpos && o_valid_new_pixel)) n_bad++;
    hs = s_valid && s_ready;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    if (hs) begin
      n_acc++;
      s_pixel = (PB+2)'(10 * (n_acc + 1));
    end
    if ((n_acc == stall_at) && (stall_left > 0)) begin
      s_valid = 1'b0;
      stall_left--;
    end else begin
      s_valid = 1'b1;
    end
  endtask

  task automatic start_frame(input int w, input int h);
    i_start  = 1'b1;
    i_width  = XB'(w);
    i_height = YB'(h);
    s_valid  = 1'b1;
    s_pixel  = (PB+2)'(10);
    tidx = 0; n_acc = 0;
    n_push = 0; n_l = 0; n_c = 0; n_r = 0; n_rowm = 0; n_done = 0; n_busy = 0; n_bad = 0;
  endtask

  logic [5:0] e1 [0:13];
  logic [5:0] e2 [3:10];

  initial begin
    stall_at = 99; stall_left = 0;
    e1 = '{6'b000000, 6'b000000, 6'b100000, 6'b110000, 6'b101000, 6'b101000, 6'b000100,
           6'b100000, 6'b110010, 6'b101010, 6'b101010, 6'b000110, 6'b000001, 6'b000000};
    e2 = '{6'b110010, 6'b000000, 6'b000000, 6'b000000, 6'b101010, 6'b101010, 6'b000110,
           6'b000001};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {o_valid_new_pixel, o_valid_lpos, o_valid_cpos, o_valid_rpos,
                          o_rowM, o_done, o_busy, s_ready}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // W=4, H=2, continuous stream
    start_frame(4, 2);
    repeat (14) step();
    for (int i = 0; i < 14; i++) check($sformatf("w4h2_code[%0d]", i), tr[i], e1[i]);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w4h2_pix_r0[%0d]", i), tp[2+i], 32'(10*(i+1)));
      check($sformatf("w4h2_pix_r1[%0d]", i), tp[7+i], 32'(10*(i+5)));
    end
    check("w4h2_rpos_pix_hold", tp[11], 80);
    check("w4h2_busy_prime", tbsy[1], 1);
    check("w4h2_busy_flush", tbsy[10], 1);
    check("w4h2_busy_done", tbsy[11], 0);
    check("w4h2_ready_flush", trdy[5], 0);
    check("w4h2_ready_run", trdy[3], 1);

    // W=4, H=1, three-cycle stall after the second pixel
    stall_at = 2; stall_left = 3;
    start_frame(4, 1);
    repeat (12) step();
    stall_at = 99;
    for (int i = 3; i <= 10; i++) check($sformatf("stall_code[%0d]", i), tr[i], e2[i]);
    check("stall_pix_after", tp[7], 30);
    check("stall_strobes", n_l + n_c + n_r, 4);
    check("stall_lpos", n_l, 1);
    check("stall_rpos", n_r, 1);
    check("stall_push", n_push, 4);

    // W=2, H=3: lpos then rpos per row
    start_frame(2, 3);
    repeat (13) step();
    check("w2_lpos", n_l, 3);
    check("w2_cpos", n_c, 0);
    check("w2_rpos", n_r, 3);
    check("w2_push", n_push, 6);
    check("w2_rowm", n_rowm, 2);
    check("w2_done", n_done, 1);
    check("w2_busy_cycles", n_busy, 9);
    check("w2_done_pos", tr[11], 6'b000001);
    check("w2_onehot", n_bad, 0);

    // Degenerate frames
    start_frame(1, 3);
    repeat (4) step();
    check("w1_done_pos", tr[2], 6'b000001);
    check("w1_no_done_early", tr[1], 0);
    check("w1_activity", n_push + n_l + n_c + n_r, 0);
    start_frame(4, 0);
    repeat (4) step();
    check("h0_done_pos", tr[2], 6'b000001);
    check("h0_activity", n_push + n_l + n_c + n_r + int'(tbsy[1]), 0);

    // Reset mid-RUN of a W=5 frame, then a clean W=3 frame
    start_frame(5, 1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();
    check("rst_mid_code", tr[4], 0);
    check("rst_mid_ready", trdy[4], 0);
    check("rst_mid_busy", tbsy[4], 0);
    check("rst_mid_no_done", n_done, 0);
    check("rst_mid_push", n_push, 2);
    start_frame(3, 1);
    repeat (8) step();
    check("after_rst_l", n_l, 1);
    check("after_rst_c", n_c, 1);
    check("after_rst_r", n_r, 1);
    check("after_rst_cpos_code", tr[4], 6'b101010);
    check("after_rst_done_pos", tr[6], 6'b000001);

    // i_start re-pulsed while busy is ignored
    start_frame(4, 1);
    repeat (3) step();
    i_start = 1'b1;
    i_width = XB'(2);
    repeat (8) step();
    check("restart_cpos", n_c, 2);
    check("restart_rpos_pos", tr[6], 6'b000110);
    check("restart_done_pos", tr[7], 6'b000001);
    check("restart_done_cnt", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
